// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle: mtc0/mfc0 access, exception inputs and the flush/redirect outputs.
interface cp0_if;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    // No valid/ready handshake here: every input is qualified by its own level each cycle,
    // req is a same-cycle combinational flush, and state changes take effect on the next posedge.
    modport master (
        output en, addr, wdata, vpc, bd_in, exc_in, hw_int, eret,
        input  rdata, req, epc_out
    );

    modport slave (
        input  en, addr, wdata, vpc, bd_in, exc_in, hw_int, eret,
        output rdata, req, epc_out
    );
endinterface

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0 in the M stage: SR/Cause/EPC/PRId, interrupt vs. exception arbitration,
// and the EPC source for eret.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h1907_2022,
    parameter logic [5:0]  IM_RESET   = 6'h00
) (
    input logic   clk,
    input logic   reset,
    cp0_if.slave  bus
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic [31:0] vpc_al;
    logic [31:0] victim_pc;
    logic [31:0] sr;
    logic [31:0] cause;

    // EXL blocks both sources so handlers never nest.
    assign int_req   = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req   = (bus.exc_in != 5'd0) & ~exl;
    assign take      = int_req | exc_req;
    assign bus.req   = take & ~reset;

    assign vpc_al    = bus.vpc & ~32'd3;
    assign victim_pc = bus.bd_in ? vpc_al - 32'd4 : vpc_al;

    assign sr    = {16'b0, im, 8'b0, exl, ie};
    assign cause = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            5'd12:   bus.rdata = sr;
            5'd13:   bus.rdata = cause;
            5'd14:   bus.rdata = epc;
            5'd15:   bus.rdata = PRID_VALUE;
            default: bus.rdata = 32'd0;
        endcase
    end

    // Forward a same-cycle mtc0 EPC so an eret right behind it returns to the new address.
    assign bus.epc_out = (bus.en & ~bus.req & (bus.addr == 5'd14)) ? bus.wdata : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= IM_RESET;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= bus.hw_int;
            if (take) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : bus.exc_in;
                bd       <= bus.bd_in;
                epc      <= victim_pc;
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (bus.en) begin
                if (bus.addr == 5'd12) begin
                    im  <= bus.wdata[15:10];
                    exl <= bus.wdata[1];
                    ie  <= bus.wdata[0];
                end else if (bus.addr == 5'd14) begin
                    epc <= bus.wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed sequences with a queued scoreboard of expected outputs.
module tb_cp0_unit;
    localparam logic [31:0] PRID = 32'h1907_2022;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  sel_q[$];
    string       tag_q[$];

    cp0_if bus ();

    cp0_unit #(.PRID_VALUE(PRID), .IM_RESET(6'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // sel: 0 = rdata, 1 = req, 2 = epc_out
    task automatic expect_out(input string tag, input logic [1:0] sel, input logic [31:0] v);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        logic [31:0] e;
        logic [1:0]  s;
        string       t;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            t = tag_q.pop_front();
            case (s)
                2'd0:    check(t, bus.rdata, e);
                2'd1:    check(t, {31'd0, bus.req}, e);
                default: check(t, bus.epc_out, e);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en     = 1'b0;
        bus.addr   = 5'd0;
        bus.wdata  = 32'd0;
        bus.vpc    = 32'd0;
        bus.bd_in  = 1'b0;
        bus.exc_in = 5'd0;
        bus.eret   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        idle();
        bus.addr = a;
        expect_out(tag, 2'd0, exp);
        step();
    endtask

    task automatic do_eret();
        idle();
        bus.eret = 1'b1;
        expect_out("eret_req", 2'd1, 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.hw_int = 6'd0;
        bus.exc_in = 5'd4;
        expect_out("req_in_reset", 2'd1, 32'd0);
        step();
        expect_out("req_in_reset2", 2'd1, 32'd0);
        step();
        reset = 1'b0;

        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_prid", 5'd15, PRID);

        // SR write masks unused bits; EXL gets set, so clear it with eret before the interrupt.
        idle();
        bus.en = 1'b1; bus.addr = 5'd12; bus.wdata = 32'hFFFF_FC03;
        expect_out("mtc0_sr_req", 2'd1, 32'd0);
        step();
        rd("sr_fc03", 5'd12, 32'h0000_FC03);
        do_eret();
        rd("sr_fc01", 5'd12, 32'h0000_FC01);

        idle();
        bus.hw_int = 6'b000100; bus.vpc = 32'h0000_1000;
        expect_out("int_req", 2'd1, 32'd1);
        step();
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr", 5'd12, 32'h0000_FC03);
        rd("int_epc", 5'd14, 32'h0000_1000);
        expect_out("int_exl_blocks", 2'd1, 32'd0);
        rd("int_epc2", 5'd14, 32'h0000_1000);
        bus.hw_int = 6'd0;
        do_eret();

        // Exception in a delay slot.
        idle();
        bus.exc_in = 5'd12; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b1;
        expect_out("exc_req", 2'd1, 32'd1);
        step();
        rd("exc_cause", 5'd13, 32'h8000_0030);
        expect_out("exc_epc_out", 2'd2, 32'h0000_300C);
        rd("exc_epc", 5'd14, 32'h0000_300C);

        // No nesting while EXL=1.
        idle();
        bus.exc_in = 5'd4; bus.vpc = 32'h0000_5000;
        expect_out("nest_req", 2'd1, 32'd0);
        step();
        rd("nest_epc", 5'd14, 32'h0000_300C);
        rd("nest_cause", 5'd13, 32'h8000_0030);
        do_eret();
        idle();
        bus.exc_in = 5'd4; bus.vpc = 32'h0000_5002;
        expect_out("retake_req", 2'd1, 32'd1);
        step();
        rd("retake_epc", 5'd14, 32'h0000_5000);
        rd("retake_cause", 5'd13, 32'h0000_0010);

        // mtc0 EPC alongside eret: forwarded to epc_out, but eret wins the register update.
        idle();
        bus.en = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h0000_3400; bus.eret = 1'b1;
        expect_out("fwd_epc_out", 2'd2, 32'h0000_3400);
        step();
        rd("fwd_epc_kept", 5'd14, 32'h0000_5000);
        rd("fwd_sr", 5'd12, 32'h0000_FC01);

        // Interrupt plus mtc0 SR in the same cycle: the write is dropped.
        idle();
        bus.hw_int = 6'b000001; bus.en = 1'b1; bus.addr = 5'd12; bus.vpc = 32'h0000_7004;
        expect_out("drop_req", 2'd1, 32'd1);
        expect_out("drop_epc_out", 2'd2, 32'h0000_5000);
        step();
        bus.hw_int = 6'd0;
        rd("drop_sr", 5'd12, 32'h0000_FC03);
        idle();
        bus.en = 1'b1; bus.addr = 5'd13; bus.wdata = 32'hFFFF_FFFF;
        step();
        rd("cause_ro", 5'd13, 32'h0000_0000);
        rd("drop_epc", 5'd14, 32'h0000_7004);

        // Direct EPC write, then EPC wrap for a delay-slot victim at address 0.
        idle();
        bus.en = 1'b1; bus.addr = 5'd14; bus.wdata = 32'hABCD_1234;
        step();
        rd("epc_write", 5'd14, 32'hABCD_1234);
        do_eret();
        idle();
        bus.exc_in = 5'd8; bus.vpc = 32'h0000_0002; bus.bd_in = 1'b1;
        expect_out("wrap_req", 2'd1, 32'd1);
        step();
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        for (int i = 0; i < 8; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(16, 31));
            if (i < 4) a = 5'($urandom_range(0, 11));
            rd("unmapped", a, 32'd0);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
